sigdel_decimator: RTL and testbench

Sigma-delta bitstream demodulator: the receive-side counterpart of the team's first-order sigma-delta modulator. It accepts the 1-bit density-modulated stream, runs it through a second-order CIC (sinc²) decimation filter and emits one unsigned 8-bit sample every R enabled cycles. It sits in the tile top alongside the modulator, so a bench or board can loop the modulator's bitstream back and recover the original code.

---
 rtl/sigdel_decimator.sv | 69 ++++++
 tb/tb_sigdel_decimator.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sigdel_decimator.sv
// Second-order CIC (sinc^2) decimator for a 1-bit sigma-delta stream.
// Emits one saturated unsigned 8-bit sample every 2**R_LOG2 enabled cycles.
module sigdel_decimator #(
  parameter int R_LOG2 = 5,
  parameter int W      = 2*R_LOG2 + 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       restart,
  input  logic       bit_in,
  output logic [7:0] sample_out,
  output logic       sample_valid
);

  localparam int SHIFT = 2*R_LOG2 - 8;

  typedef enum logic [1:0] {SETTLE_0, SETTLE_1, RUN} settle_t;

  settle_t           settle;
  logic [W-1:0]      i1, i2, d1, d2;
  logic [W-1:0]      c1, c2, y_scaled;
  logic [R_LOG2-1:0] phase;
  logic [7:0]        y_sat;
  logic              tick;

  // Comb stage works on the pre-update i2; modular subtraction cancels integrator wrap.
  always_comb begin
    c1       = i2 - d1;
    c2       = c1 - d2;
    y_scaled = c2 >> SHIFT;
    y_sat    = (y_scaled > W'(255)) ? 8'hFF : y_scaled[7:0];
    tick     = (phase == '1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      i1           <= '0;
      i2           <= '0;
      d1           <= '0;
      d2           <= '0;
      phase        <= '0;
      settle       <= SETTLE_0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else if (!ena) begin
      sample_valid <= 1'b0;
    end else begin
      i1           <= i1 + {{(W-1){1'b0}}, bit_in};
      i2           <= i2 + i1;
      phase        <= phase + R_LOG2'(1);
      sample_valid <= 1'b0;
      if (tick) begin
        d1 <= i2;
        d2 <= c1;
        // The first two ticks only prime the comb delays.
        case (settle)
          SETTLE_0: settle <= SETTLE_1;
          SETTLE_1: settle <= RUN;
          default: begin
            sample_out   <= y_sat;
            sample_valid <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sigdel_decimator.sv
// Randomized scoreboard bench for sigdel_decimator (R = 32); the reference is
// a direct triangular-window FIR over the enabled-cycle bit history.
module tb_sigdel_decimator;

  localparam int R_LOG2 = 5;
  localparam int R      = 1 << R_LOG2;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       restart;
  logic       bit_in;
  logic [7:0] sample_out;
  logic       sample_valid;

  sigdel_decimator #(.R_LOG2(R_LOG2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .restart      (restart),
    .bit_in       (bit_in),
    .sample_out   (sample_out),
    .sample_valid (sample_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         v;
    logic [7:0] o;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state: enabled cycles since clear and recent bit history.
  int         cnt = 0;
  bit         hist[$];
  logic [7:0] model_out = 8'd0;

  // Pattern generator state.
  int         pat_idx = 0;
  int         sd_acc  = 0;
  int         sd_code = 0;

  function automatic logic [7:0] fir_sample();
    int y = 0;
    int n = hist.size();
    for (int u = 1; u < 2*R; u++) begin
      int wgt = (u < R) ? u : 2*R - u;
      if (hist[n-2-u]) y += wgt;
    end
    y = y >> (2*R_LOG2 - 8);
    return (y > 255) ? 8'd255 : 8'(y);
  endfunction

  // Drive one clock's inputs, predict the outcome of the next edge, advance.
  task automatic step(input logic rst, input logic rs, input logic en, input logic b);
    exp_t e;
    rst_n   = rst;
    restart = rs;
    ena     = en;
    bit_in  = b;
    e.v = 1'b0;
    if (!rst || rs) begin
      cnt = 0;
      hist.delete();
      model_out = 8'd0;
    end else if (en) begin
      cnt++;
      hist.push_back(b);
      while (hist.size() > 2*R + 1) void'(hist.pop_front());
      if ((cnt % R) == 0 && cnt >= 3*R) begin
        model_out = fir_sample();
        e.v = 1'b1;
      end
    end
    e.o = model_out;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic pat_bit(input int mode);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (pat_idx % 2) == 0;
      3:       return (pat_idx % 4) == 0;
      4:       return (pat_idx % 4) != 3;
      default: return (sd_acc + sd_code) >= 256;
    endcase
  endfunction

  // mode: 0 zeros, 1 ones, 2 alternating, 3 one-in-four, 4 three-in-four, 5 sigma-delta of sd_code.
  task automatic run(input int mode, input int n, input int duty);
    for (int k = 0; k < n; k++) begin
      logic en;
      logic b;
      en = (duty >= 100) ? 1'b1 : (($urandom % 100) < duty);
      b  = pat_bit(mode);
      step(1'b1, 1'b0, en, b);
      if (en) begin
        pat_idx++;
        if (mode == 5) sd_acc = (sd_acc + sd_code) % 256;
      end
    end
  endtask

  // Run until the next enabled edge would be a tick, then clear on that edge.
  task automatic clear_on_tick(input logic use_reset, input int hold);
    for (int k = 0; k < 4*R && (cnt % R) != R - 1; k++) run(2, 1, 100);
    for (int k = 0; k < hold; k++) step(use_reset ? 1'b0 : 1'b1, use_reset ? 1'b0 : 1'b1, 1'b1, pat_bit(2));
  endtask

  // Monitor: one scoreboard record is consumed per clock edge.
  initial begin
    exp_t r;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        tests++;
        if (sample_valid !== r.v) begin
          fails++;
          $display("FAIL valid @%0t: got %b expected %b", $time, sample_valid, r.v);
        end
        tests++;
        if (sample_out !== r.o) begin
          fails++;
          $display("FAIL sample_out @%0t: got %0d expected %0d", $time, sample_out, r.o);
        end
      end
    end
  end

  initial begin
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);

    run(1, 8*R, 100);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    run(0, 6*R, 100);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    run(2, 6*R, 100);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    run(3, 6*R, 100);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    run(4, 6*R, 100);

    // Loopback-style first-order sigma-delta stream, code change without clear.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    sd_acc  = 0;
    sd_code = 8'h40;
    run(5, 8*R, 100);
    sd_code = 8'hC0;
    run(5, 8*R, 100);

    // Gapped enable with alternating input.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    pat_idx = 0;
    run(2, 20*R, 50);

    // Restart / reset landing on tick edges, single and held.
    clear_on_tick(1'b0, 1);
    run(2, 5*R, 100);
    clear_on_tick(1'b0, 3);
    run(2, 4*R, 70);
    clear_on_tick(1'b1, 1);
    run(4, 5*R, 100);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    run(3, 4*R, 100);

    // Long run of ones forces integrator wrap many times over.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    run(1, 4 * (1 << (2*R_LOG2 + 1)) + 3*R, 100);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
